// File: rtl/display_scan_hms.sv
// Six-digit HH:MM:SS multiplexed display scanner with frame snapshots,
// field-blink for the set modes and a one-stage registered output pipeline.
module display_scan_hms (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena_scan,
  input  logic       ena_blink,
  input  logic [1:0] select_mode,
  input  logic [5:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [2:0] idx;
  logic       blink_phase;
  logic       scan_pend;
  logic [5:0] snap_hour, snap_min, snap_sec;

  logic [5:0] field_val;
  logic [1:0] field_sel;
  logic [3:0] tens, ones, digit;
  logic       blank;
  logic [6:0] seg_nxt;
  logic [5:0] an_nxt;
  logic       dp_nxt;

  // Restoring compare/subtract split of 0..59 into tens and ones.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    field_val = snap_sec;
    field_sel = 2'd1;
    case (idx)
      3'd2, 3'd3: begin field_val = snap_min;  field_sel = 2'd2; end
      3'd4, 3'd5: begin field_val = snap_hour; field_sel = 2'd3; end
      default:    begin field_val = snap_sec;  field_sel = 2'd1; end
    endcase

    {tens, ones} = to_bcd(field_val);
    digit = idx[0] ? tens : ones;

    // Blink uses the live mode/phase, not anything frozen with the snapshot.
    blank = blink_phase && (select_mode == field_sel);

    if (blank)
      seg_nxt = SEG_BLANK;
    else if (field_val >= 6'd60)
      seg_nxt = SEG_DASH;
    else
      seg_nxt = seg_code(digit);

    an_nxt = ~(6'b000001 << idx);
    dp_nxt = !((idx == 3'd2) || (idx == 3'd4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= 3'd0;
      blink_phase <= 1'b0;
      scan_pend   <= 1'b0;
      snap_hour   <= 6'd0;
      snap_min    <= 6'd0;
      snap_sec    <= 6'd0;
      seg         <= SEG_BLANK;
      an          <= 6'b111111;
      dp          <= 1'b1;
    end else begin
      scan_pend <= ena_scan;
      if (ena_blink)
        blink_phase <= ~blink_phase;
      if (ena_scan) begin
        if (idx >= 3'd5) begin
          idx       <= 3'd0;
          snap_hour <= hour;
          snap_min  <= min;
          snap_sec  <= sec;
        end else begin
          idx <= idx + 3'd1;
        end
      end
      if (scan_pend) begin
        seg <= seg_nxt;
        an  <= an_nxt;
        dp  <= dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_hms.sv
// Bench for display_scan_hms: arithmetic reference model checked every cycle,
// plus directed literal checks for the documented scan/blink/reset scenarios.
module tb_display_scan_hms;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena_scan = 1'b0;
  logic       ena_blink = 1'b0;
  logic [1:0] select_mode = 2'd0;
  logic [5:0] hour = 6'd0, min = 6'd0, sec = 6'd0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  display_scan_hms dut (
    .clk(clk), .rst(rst), .ena_scan(ena_scan), .ena_blink(ena_blink),
    .select_mode(select_mode), .hour(hour), .min(min), .sec(sec),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: digit position -> field, value split by / and %.
  logic [6:0] codes [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
  int         m_pos, m_blink, m_pend;
  int         m_snap [0:2];
  logic [6:0] m_seg;
  logic [5:0] m_an;
  logic       m_dp;

  always @(posedge clk) begin
    int field, val;
    if (rst) begin
      m_pos = 0; m_blink = 0; m_pend = 0;
      m_snap[0] = 0; m_snap[1] = 0; m_snap[2] = 0;
      m_seg = 7'h7f; m_an = 6'h3f; m_dp = 1'b1;
    end else begin
      if (m_pend != 0) begin
        field = m_pos / 2;
        val   = m_snap[field];
        if (m_blink == 1 && int'(select_mode) == field + 1) m_seg = 7'h7f;
        else if (val >= 60) m_seg = 7'b0111111;
        else m_seg = codes[(m_pos % 2 == 1) ? val / 10 : val % 10];
        m_an = 6'h3f;
        m_an[m_pos] = 1'b0;
        m_dp = !(m_pos == 2 || m_pos == 4);
      end
      m_pend = ena_scan ? 1 : 0;
      if (ena_blink) m_blink = 1 - m_blink;
      if (ena_scan) begin
        m_pos = (m_pos + 1) % 6;
        if (m_pos == 0) begin
          m_snap[0] = int'(sec); m_snap[1] = int'(min); m_snap[2] = int'(hour);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      tests = tests + 1;
      if (seg !== m_seg || an !== m_an || dp !== m_dp) begin
        fails = fails + 1;
        $display("FAIL model t=%0t: seg=%b an=%b dp=%b, expected seg=%b an=%b dp=%b",
                 $time, seg, an, dp, m_seg, m_an, m_dp);
      end
    end
  end

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic tick();
    ena_scan = 1'b1;
    @(negedge clk);
    ena_scan = 1'b0;
    @(negedge clk);
  endtask

  task automatic blink_pulse();
    ena_blink = 1'b1;
    @(negedge clk);
    ena_blink = 1'b0;
  endtask

  logic [6:0] f2_seg [0:5] = '{7'b0000010, 7'b0010010, 7'b0011001,
                               7'b0110000, 7'b0100100, 7'b1111001};
  logic [5:0] an_walk [0:5] = '{6'b111110, 6'b111101, 6'b111011,
                                6'b110111, 6'b101111, 6'b011111};

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    check("reset_an", {1'b0, an}, 7'b0111111);
    check("reset_seg", seg, 7'b1111111);
    check("reset_dp", {6'd0, dp}, 7'd1);
    hour = 6'd12; min = 6'd34; sec = 6'd56;
    repeat (4) @(negedge clk);
    check("idle_hold_an", {1'b0, an}, 7'b0111111);

    // First frame: zero snapshot on idx1..5, then 56 after wrap.
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("frame1_an", {1'b0, an}, {1'b0, an_walk[k % 6]});
      check("frame1_seg", seg, (k == 6) ? 7'b0000010 : 7'b1000000);
    end

    // Second frame; sec changes mid-frame and shows only after the wrap.
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("frame2_seg", seg, (k == 6) ? 7'b1111000 : f2_seg[k % 6]);
      check("frame2_dp", {6'd0, dp}, (k == 2 || k == 4) ? 7'd0 : 7'd1);
      if (k == 3) sec = 6'd57;
    end

    // Out-of-range minute shows dashes on both minute digits.
    min = 6'd61;
    repeat (6) tick();
    tick(); tick();
    check("dash_min_ones", seg, 7'b0111111);
    tick();
    check("dash_min_tens", seg, 7'b0111111);

    // Hour blink: blanked digits keep their enable.
    select_mode = 2'b11;
    blink_pulse();
    tick();
    check("blink_h_ones", seg, 7'b1111111);
    check("blink_h_ones_an", {1'b0, an}, 7'b0101111);
    tick();
    check("blink_h_tens", seg, 7'b1111111);
    tick();
    check("blink_sec_ok", seg, 7'b1111000);
    blink_pulse();
    repeat (4) tick();
    check("unblink_h_ones", seg, 7'b0100100);
    tick();
    check("unblink_h_tens", seg, 7'b1111001);

    // Reset at idx3 together with ena_scan, with blink_phase set beforehand.
    blink_pulse();
    repeat (4) tick();
    rst = 1'b1; ena_scan = 1'b1;
    @(negedge clk);
    rst = 1'b0; ena_scan = 1'b0;
    check("rst_scan_an", {1'b0, an}, 7'b0111111);
    check("rst_scan_seg", seg, 7'b1111111);
    tick();
    check("post_rst_an", {1'b0, an}, 7'b0111101);
    repeat (3) tick();
    check("post_rst_no_blink", seg, 7'b1000000);
    select_mode = 2'b00;

    // Randomized stimulus, checked by the per-cycle model compare.
    for (int n = 0; n < 4000; n++) begin
      int burst;
      burst = ((n / 100) % 7 == 3) ? 1 : 0;
      ena_scan  = (burst == 1) ? 1'b1 : (($urandom % 3) == 0);
      ena_blink = (($urandom % 25) == 0);
      rst       = (($urandom % 600) == 0);
      if (($urandom % 150) == 0) select_mode = 2'($urandom);
      if (($urandom % 40) == 0) begin
        hour = 6'($urandom); min = 6'($urandom_range(0, 59)); sec = 6'($urandom);
      end
      @(negedge clk);
    end
    rst = 1'b0; ena_scan = 1'b0; ena_blink = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_hms.md
DISPLAY_SCAN_HMS -- requirements
Module: display_scan_hms

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  system clock; the single clock, all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ena_scan  in  1  one-clk digit-advance tick (~1 kHz).
REQ-005 ena_blink  in  1  one-clk blink-toggle tick (~2 Hz).
REQ-006 select_mode  in  2  00 run, 01 set sec, 10 set min, 11 set hour.
REQ-007 hour, min, sec  in  6 each  unsigned binary time from the hour/min/sec counters.
REQ-008 seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 an  out  6  digit enables, one-hot active-low, registered; bit0 = rightmost digit.
REQ-010 dp  out  1  decimal point, active-low, registered.

Function
REQ-011 SHALL keep a 3-bit digit index idx (0..5); on an ena_scan cycle idx advances by 1 and wraps 5->0; no other values are reachable.
REQ-012 Digit map SHALL be: idx0 sec ones, idx1 sec tens, idx2 min ones, idx3 min tens, idx4 hour ones, idx5 hour tens.
REQ-013 On the ena_scan edge where idx goes 5->0, hour/min/sec SHALL be captured into snapshot registers; all six digits of one frame use the same snapshot (no tearing).
REQ-014 Outputs SHALL be a one-stage pipeline: an/seg/dp for the new idx appear exactly one clk after the ena_scan edge that set idx; between ticks the outputs hold.
REQ-015 an SHALL drive low only bit idx; all other bits high.
REQ-016 Binary-to-BCD SHALL be tens = value/10 and ones = value mod 10 for values 0..59, implemented without a divider (compare/subtract).
REQ-017 Snapshot values 60..63 SHALL display a dash (seg = 0111111) on both digits of that field.
REQ-018 Encoding 0..9 (active-low, gfedcba): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-019 Leading zeros SHALL be shown (hour 5 displays "05").
REQ-020 dp SHALL be low on idx2 and idx4 (field separators) and high otherwise.
REQ-021 A 1-bit blink_phase SHALL toggle on each ena_blink cycle.
REQ-022 When blink_phase=1, the two digits of the field selected by select_mode (01 sec, 10 min, 11 hour) SHALL be blanked (seg = 1111111, dp unchanged, an still asserted); select_mode 00 never blanks.
REQ-023 Blanking SHALL use select_mode and blink_phase sampled in the same pipeline stage as the digit value (not the snapshot).
REQ-024 ena_scan and ena_blink asserted on the same cycle SHALL both take effect.
REQ-025 ena_scan held high continuously SHALL advance idx every clk.

Reset
REQ-026 While rst=1 at a clk edge: idx=0, blink_phase=0, snapshots=0, an=111111, seg=1111111, dp=1.
REQ-027 rst SHALL take priority over ena_scan and ena_blink on the same edge.
REQ-028 After rst deasserts, all outputs SHALL remain at reset values until one clk after the first ena_scan; the first displayed digit is idx1 (sec tens) from the zero snapshot.
REQ-029 Reset mid-frame SHALL abandon the frame; the next snapshot is taken on the next 5->0 wrap.

Verification
REQ-030 Reset then 6 ena_scan ticks with hour=12, min=34, sec=56 -> an walks 111101,111011,110111,101111,011111,111110; seg shows 0 on idx1..5 (zero snapshot) and 6 on idx0 after wrap.
REQ-031 Hold 12:34:56 for a second frame -> seg per idx0..5 = 0000010, 0010010, 0011001, 0110000, 0100100, 1111001; dp low only on idx2, idx4.
REQ-032 Change sec 56->57 at idx3 mid-frame -> sec digits in that frame still show 56; 57 appears after the next wrap.
REQ-033 select_mode=11, one ena_blink pulse, scan a frame -> idx4/idx5 seg=1111111 with an asserted, others normal; a second ena_blink restores them.
REQ-034 min=61 -> idx2 and idx3 seg=0111111.
REQ-035 rst asserted at idx3 together with ena_scan -> next edge an=111111, seg=1111111, idx=0, blink_phase=0.
